// File: rtl/fetch_queue.sv
// fetch_queue: decode-side end of the instruction-fetch interface.
//   Buffers fetched {pc, instr} pairs in a small circular FIFO.
//   Presents the oldest entry to decode with a valid/ready handshake.
//   Produces the next fetch PC and the IFU hold signal.
//   On a redirect, discards every queued wrong-path entry and steers fetch to the target.
// Ports:
//   clk, reset              rising-edge clock; asynchronous active-high reset
//   if_pc, if_instr         current fetch PC and its instruction word from the IFU
//   if_stall, if_pc_next    IFU hold request and the PC the IFU loads next
//   redirect, redirect_pc   taken branch/jump and its target byte address
//   id_valid, id_ready      decode handshake for the head entry
//   id_instr, id_pc         head entry contents
//   count                   number of entries currently held (0..DEPTH)
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  output logic             if_stall,
  output logic [31:0]      if_pc_next,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic full;
  logic empty;
  logic pop;
  logic push;

  always_comb begin
    full     = (count == FullCount);
    empty    = (count == '0);
    // A redirect kills the head entry in the same cycle, so decode never sees it.
    id_valid = ~empty & ~redirect;
    pop      = id_valid & id_ready;
    // A full queue can still accept when the head leaves in the same cycle.
    push     = ~redirect & (~full | pop);
    if_stall = ~redirect & full & ~pop;
    if (redirect) begin
      if_pc_next = redirect_pc & 32'hFFFF_FFFC;
    end else if (if_stall) begin
      if_pc_next = if_pc;
    end else begin
      if_pc_next = if_pc + 32'd4;
    end
    id_pc    = pc_mem[rd_ptr];
    id_instr = instr_mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (redirect) begin
      // Flush by catching the read pointer up to the write pointer.
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= if_pc;
        instr_mem[wr_ptr] <= if_instr;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus for fetch_queue, checked against a
// queue-based reference model. A tiny IFU model supplies if_pc/if_instr.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_stall;
  logic [31:0] if_pc_next;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  count;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  logic [63:0] mq[$];  // {pc, instr}, head at index 0

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr), .if_stall(if_stall),
    .if_pc_next(if_pc_next), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  // IFU: holds PC while stalled, shares the queue's reset.
  always @(posedge clk or posedge reset) begin
    if (reset) if_pc <= 32'h3000;
    else if (!if_stall) if_pc <= if_pc_next;
  end
  assign if_instr = {if_pc[15:0] ^ 16'hA5C3, ~if_pc[15:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check settled outputs against the model, advance.
  task automatic cycle(input logic rd, input logic red, input logic [31:0] rpc);
    logic ev, pop, push, stall, full;
    logic [31:0] pcn, cur_pc, cur_instr;
    id_ready = rd; redirect = red; redirect_pc = rpc;
    #2;
    full  = (mq.size() == DEPTH);
    ev    = (mq.size() != 0) && !red;
    pop   = ev && rd;
    push  = !red && (!full || pop);
    stall = !red && full && !pop;
    cur_pc = if_pc; cur_instr = if_instr;
    if (red) pcn = {rpc[31:2], 2'b00};
    else if (stall) pcn = cur_pc;
    else pcn = cur_pc + 32'd4;
    chk("id_valid", 32'(id_valid), 32'(ev));
    chk("count", 32'(count), mq.size());
    chk("if_stall", 32'(if_stall), 32'(stall));
    chk("if_pc_next", if_pc_next, pcn);
    if (ev) begin
      chk("id_pc", id_pc, mq[0][63:32]);
      chk("id_instr", id_instr, mq[0][31:0]);
    end
    @(posedge clk);
    if (red) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({cur_pc, cur_instr});
    end
    #1;
  endtask

  // Reset asserted away from any clock edge; effects must appear immediately.
  task automatic do_reset();
    redirect = 1'b0; id_ready = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_if_stall", 32'(if_stall), 32'd0);
    mq.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("ifu_start", if_pc, 32'h3000);

    // Sequential fetch with decode always ready.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);
    chk("seq_count", 32'(count), 32'd1);

    // Decode holds off until the queue fills and fetch stalls.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0);
    chk("stall_if_pc", if_pc, 32'h3010);
    chk("stall_id_pc", id_pc, 32'h3000);
    // Full with pop in the same cycle, then drain in order.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0);

    // Redirect with three entries queued.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h3100);
    cycle(1'b1, 1'b0, '0);
    chk("redir_head", id_pc, 32'h3100);
    cycle(1'b1, 1'b0, '0);

    // Misaligned target, then alternating pop to wrap pointers.
    cycle(1'b0, 1'b1, 32'h3102);
    for (int i = 0; i < 10; i++) cycle(i[0], 1'b0, '0);

    // Reset in mid-operation.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    do_reset();
    chk("resume_pc", if_pc, 32'h3000);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      logic r, d;
      logic [31:0] t;
      r = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 9) == 0);
      t = 32'h3000 + ($urandom & 32'h0000_0FFF);
      cycle(r, d, t);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
